// File: rtl/core_cg_enable_ctrl_pkg.sv
// core_cg_ctrl_pkg: shared types and constants for the core clock-gate enable
// controller.
//   cg_state_e  : controller state (RUN / IDLE_WAIT / GATED / WAKE), 2-bit
//   GATE_CNT_W  : width of the saturating gating-event counter
package core_cg_ctrl_pkg;

  typedef enum logic [1:0] {
    CG_RUN       = 2'd0,
    CG_IDLE_WAIT = 2'd1,
    CG_GATED     = 2'd2,
    CG_WAKE      = 2'd3
  } cg_state_e;

  localparam int unsigned GATE_CNT_W = 32;

endpackage : core_cg_ctrl_pkg

// File: rtl/core_cg_enable_ctrl_if.sv
// core_cg_enable_ctrl_if: groups the sleep/wake inputs and the gate-control
// status outputs of core_cg_enable_ctrl.
//   sleep_req_i, irq_pending_i, debug_req_i, force_on_i : requests into the controller
//   en_o, gated_o, wake_pulse_o, gate_count_o           : registered controller outputs
//   state_dbg                                           : current FSM state (observation only)
// modport master : the core/power-manager side driving requests
// modport slave  : the controller itself
interface core_cg_enable_ctrl_if;
  import core_cg_ctrl_pkg::*;

  logic                  sleep_req_i;
  logic                  irq_pending_i;
  logic                  debug_req_i;
  logic                  force_on_i;
  logic                  en_o;
  logic                  gated_o;
  logic                  wake_pulse_o;
  logic [GATE_CNT_W-1:0] gate_count_o;
  cg_state_e             state_dbg;

  modport master (
    output sleep_req_i, irq_pending_i, debug_req_i, force_on_i,
    input  en_o, gated_o, wake_pulse_o, gate_count_o, state_dbg
  );

  modport slave (
    input  sleep_req_i, irq_pending_i, debug_req_i, force_on_i,
    output en_o, gated_o, wake_pulse_o, gate_count_o, state_dbg
  );

endinterface : core_cg_enable_ctrl_if

// File: rtl/core_cg_enable_ctrl.sv
// core_cg_enable_ctrl: generates the enable for the core clock-gate cell.
// Runs on the free-running clock. Gates the core clock once sleep_req_i has
// been stable for IDLE_CYCLES edges with no wake source or force-on, and
// reopens it on interrupt, debug request or force-on, spending WAKE_CYCLES
// in a settle window before returning to RUN.
//   clk_i  : free-running (ungated) clock
//   rst_ni : asynchronous active-low reset; clock enabled while in reset
//   cg     : request inputs and registered status outputs (slave side)
// Request semantics: the inputs are levels, sampled on every rising clk_i
// edge; there is no handshake and no back-pressure. All outputs are flops
// loaded from next-state values, so en_o changes only at clk_i rising edges.
module core_cg_enable_ctrl
  import core_cg_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  core_cg_enable_ctrl_if.slave  cg
);

  localparam int unsigned MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

  cg_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [GATE_CNT_W-1:0] gate_count_q, gate_count_d;
  logic                  en_q, gated_q, wake_pulse_q;
  logic                  pulse_d, gate_inc;
  logic                  wake_src, block;

  assign wake_src = cg.irq_pending_i | cg.debug_req_i;
  assign block    = wake_src | cg.force_on_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gate_inc = 1'b0;
    pulse_d  = 1'b0;
    unique case (state_q)
      CG_RUN: begin
        if (cg.sleep_req_i && !block) begin
          state_d = CG_IDLE_WAIT;
          cnt_d   = IDLE_LOAD;
        end
      end
      CG_IDLE_WAIT: begin
        // Abort has priority over the gating edge; a later request restarts the full count.
        if (!cg.sleep_req_i || block) begin
          state_d = CG_RUN;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = CG_GATED;
          gate_inc = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CG_GATED: begin
        if (block) begin
          state_d = CG_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      CG_WAKE: begin
        // Settle window: sleep and wake sources are deliberately ignored here.
        if (cnt_q == '0) begin
          state_d = CG_RUN;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = CG_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating event counter: holds at all-ones instead of wrapping.
  always_comb begin
    gate_count_d = gate_count_q;
    if (gate_inc && (gate_count_q != '1)) begin
      gate_count_d = gate_count_q + GATE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= CG_RUN;
      cnt_q        <= '0;
      gate_count_q <= '0;
      en_q         <= 1'b1;
      gated_q      <= 1'b0;
      wake_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gate_count_q <= gate_count_d;
      en_q         <= (state_d != CG_GATED);
      gated_q      <= (state_d == CG_GATED);
      wake_pulse_q <= pulse_d;
    end
  end

  assign cg.en_o         = en_q;
  assign cg.gated_o      = gated_q;
  assign cg.wake_pulse_o = wake_pulse_q;
  assign cg.gate_count_o = gate_count_q;
  assign cg.state_dbg    = state_q;

endmodule : core_cg_enable_ctrl

// File: tb/tb_core_cg_enable_ctrl.sv
// tb_core_cg_enable_ctrl: directed bench for core_cg_enable_ctrl
// (IDLE_CYCLES=4, WAKE_CYCLES=2). Each driver step applies inputs before a
// rising edge and queues the hand-computed outputs expected after that edge;
// the monitor pops and compares one entry after every rising edge.
module tb_core_cg_enable_ctrl;
  import core_cg_ctrl_pkg::*;

  localparam int W = 35;  // {en, gated, wake_pulse, gate_count[31:0]}

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_cg_enable_ctrl_if cg_if ();

  core_cg_enable_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cg     (cg_if)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp, mon_act;
  int n_cmp  = 0;
  int n_fail = 0;
  int n_step = 0;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {cg_if.en_o, cg_if.gated_o, cg_if.wake_pulse_o, cg_if.gate_count_o};
      n_cmp++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL out_step%0d: got en=%0b gated=%0b pulse=%0b count=%h, expected en=%0b gated=%0b pulse=%0b count=%h",
                 n_step, mon_act[34], mon_act[33], mon_act[32], mon_act[31:0],
                 mon_exp[34], mon_exp[33], mon_exp[32], mon_exp[31:0]);
      end
      n_step++;
    end
  end

  task automatic check_now(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step(input logic s, input logic i, input logic d, input logic f,
                      input logic e_en, input logic e_g, input logic e_p, input logic [31:0] e_c);
    @(negedge clk);
    cg_if.sleep_req_i   = s;
    cg_if.irq_pending_i = i;
    cg_if.debug_req_i   = d;
    cg_if.force_on_i    = f;
    exp_q.push_back({e_en, e_g, e_p, e_c});
    @(posedge clk);
  endtask

  // Sleep held high from RUN: four edges still enabled, gated after the fifth.
  task automatic gate_seq(input logic [31:0] c0, input logic [31:0] c1);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1, 0, 0, c0);
    step(1, 0, 0, 0, 0, 1, 0, c1);
  endtask

  // Wake from GATED; sleep stays high throughout to show it is ignored in WAKE.
  task automatic wake_seq(input logic i, input logic d, input logic f, input logic [31:0] c);
    step(1, i, d, f, 1, 0, 0, c);
    step(1, 0, 0, 0, 1, 0, 0, c);
    step(1, 0, 0, 0, 1, 0, 1, c);
  endtask

  initial begin
    cg_if.sleep_req_i   = 1'b0;
    cg_if.irq_pending_i = 1'b0;
    cg_if.debug_req_i   = 1'b0;
    cg_if.force_on_i    = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_out", {cg_if.en_o, cg_if.gated_o, cg_if.wake_pulse_o, cg_if.gate_count_o},
              {1'b1, 1'b0, 1'b0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 1, 0, 0, 32'd0);

    // Nominal gate, stays gated with sleep low or high
    gate_seq(32'd0, 32'd1);
    step(0, 0, 0, 0, 0, 1, 0, 32'd1);
    step(1, 0, 0, 0, 0, 1, 0, 32'd1);

    // Wake on irq, then immediate new gating sequence, then wake on debug
    wake_seq(1, 0, 0, 32'd1);
    gate_seq(32'd1, 32'd2);
    wake_seq(0, 1, 0, 32'd2);
    step(0, 0, 0, 0, 1, 0, 0, 32'd2);

    // Abort mid-wait
    step(1, 0, 0, 0, 1, 0, 0, 32'd2);
    step(1, 0, 0, 0, 1, 0, 0, 32'd2);
    step(1, 1, 0, 0, 1, 0, 0, 32'd2);
    #1;
    check_now("abort_state", {33'd0, cg_if.state_dbg}, {33'd0, CG_RUN});
    step(0, 0, 0, 0, 1, 0, 0, 32'd2);

    // Abort on the gating edge, then a full-length restart with sleep still high
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1, 0, 0, 32'd2);
    step(1, 1, 0, 0, 1, 0, 0, 32'd2);
    gate_seq(32'd2, 32'd3);

    // Force-on wakes, then holds the clock on against sleep
    wake_seq(0, 0, 1, 32'd3);
    for (int k = 0; k < 20; k++) step(1, 0, 0, 1, 1, 0, 0, 32'd3);
    step(0, 0, 0, 0, 1, 0, 0, 32'd3);

    // Reset mid-gate
    gate_seq(32'd3, 32'd4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("rst_midgate", {cg_if.en_o, cg_if.gated_o, cg_if.wake_pulse_o, cg_if.gate_count_o},
              {1'b1, 1'b0, 1'b0, 32'd0});
    cg_if.sleep_req_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 1, 0, 0, 32'd0);

    // Saturation
    @(negedge clk);
    force dut.gate_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.gate_count_q;
    gate_seq(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    wake_seq(1, 0, 0, 32'hFFFF_FFFF);
    gate_seq(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wake_seq(1, 0, 0, 32'hFFFF_FFFF);
    gate_seq(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wake_seq(0, 1, 0, 32'hFFFF_FFFF);
    step(0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);

    // Final report
    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1);
  end

endmodule : tb_core_cg_enable_ctrl
